// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared widths, ALU op codes and FSM encoding for the
//                ALU command sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 4;
    localparam int ACC_W  = 8;
    localparam int CNT_W  = 4;

    // Op codes are the ALU select encodings themselves.
    localparam logic [OP_W-1:0] OP_RCADD   = 3'b111;
    localparam logic [OP_W-1:0] OP_ADD     = 3'b110;
    localparam logic [OP_W-1:0] OP_NAND    = 3'b101;
    localparam logic [OP_W-1:0] OP_ORRED   = 3'b100;
    localparam logic [OP_W-1:0] OP_PATTERN = 3'b011;
    localparam logic [OP_W-1:0] OP_CONCAT  = 3'b010;
    localparam logic [OP_W-1:0] OP_HOLD    = 3'b001;
    localparam logic [OP_W-1:0] OP_ZERO    = 3'b000;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_CLEAR = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer_if
//  Description : Command handshake plus ALU/accumulator control bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_sequencer_if;
    import alu_seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [CNT_W-1:0]  cmd_count;
    logic              abort;
    logic [ACC_W-1:0]  acc_value;
    logic [OP_W-1:0]   alu_sel;
    logic [DATA_W-1:0] alu_a;
    logic              acc_load;
    logic              acc_clear;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [ACC_W-1:0]  result;

    // master: command source plus the accumulator it feeds back
    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, abort, acc_value,
        input  cmd_ready, alu_sel, alu_a, acc_load, acc_clear,
        input  busy, done, aborted, result
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, abort, acc_value,
        output cmd_ready, alu_sel, alu_a, acc_load, acc_clear,
        output busy, done, aborted, result
    );

endinterface
`default_nettype wire

// File: rtl/seq_step_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_step_counter
//  Description : Loadable step down-counter flagging the final step (rem==1).
//  Revision    : 1.0  initial release
// ============================================================================
module seq_step_counter #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_rem;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rem <= '0;
        end else if (i_load) begin
            r_rem <= i_load_val;
        end else if (i_dec && (r_rem != '0)) begin
            r_rem <= r_rem - 1'b1;
        end
    end

    assign o_last = (r_rem == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Command-driven controller stepping an ALU + accumulator
//                pair N times per accepted command, with abort and clear.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic           CLK,
    input  logic           RESET,
    alu_sequencer_if.slave bus
);

    state_t            r_state;
    logic              r_cmd_ready;
    logic              r_acc_load;
    logic              r_acc_clear;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;
    logic [OP_W-1:0]   r_alu_sel;
    logic [DATA_W-1:0] r_alu_a;
    logic [ACC_W-1:0]  r_result;

    logic              w_accept;
    logic              w_exec;
    logic              w_last;

    assign w_accept = bus.cmd_valid & r_cmd_ready;
    assign w_exec   = (r_state == ST_EXEC);

    seq_step_counter #(
        .CNT_W      (CNT_W)
    ) u_step_counter (
        .CLK        (CLK),
        .RESET      (RESET),
        .i_load     (w_accept),
        .i_load_val (bus.cmd_count),
        .i_dec      (w_exec),
        .o_last     (w_last)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_acc_load  <= 1'b0;
            r_acc_clear <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_alu_sel   <= OP_HOLD;
            r_alu_a     <= '0;
            r_result    <= '0;
        end else begin
            r_done      <= 1'b0;
            r_acc_clear <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_aborted   <= 1'b0;
                        if (bus.cmd_count == '0) begin
                            r_state     <= ST_CLEAR;
                            r_acc_clear <= 1'b1;
                        end else begin
                            r_state    <= ST_EXEC;
                            r_acc_load <= 1'b1;
                            r_alu_sel  <= bus.cmd_op;
                            r_alu_a    <= bus.cmd_data;
                        end
                    end
                end
                ST_EXEC: begin
                    // abort takes precedence over the final step
                    if (bus.abort || w_last) begin
                        r_state    <= ST_DONE;
                        r_acc_load <= 1'b0;
                        r_done     <= 1'b1;
                        r_aborted  <= bus.abort;
                        r_alu_sel  <= OP_HOLD;
                        r_alu_a    <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_result    <= bus.acc_value;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Abort must suppress the load in the very cycle it is seen.
    assign bus.acc_load  = r_acc_load & ~bus.abort;
    assign bus.cmd_ready = r_cmd_ready;
    assign bus.acc_clear = r_acc_clear;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.aborted   = r_aborted;
    assign bus.alu_sel   = r_alu_sel;
    assign bus.alu_a     = r_alu_a;
    assign bus.result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Directed and randomized self-checking bench for alu_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stand-in ALU: any deterministic function will do, the sequencer never looks at data.
    function automatic logic [7:0] alu_f(input logic [2:0] sel, input logic [3:0] a, input logic [7:0] b);
        case (sel)
            3'b111, 3'b110: return b + {4'b0000, a};
            3'b101:         return ~(b ^ {a, a});
            3'b100:         return {7'b0, |{a, b}};
            3'b011:         return {a, ~a};
            3'b010:         return {a, b[3:0]};
            3'b001:         return b;
            default:        return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] model_apply(input logic [2:0] op, input logic [3:0] a,
                                               input logic [7:0] acc0, input int n);
        logic [7:0] v = acc0;
        for (int i = 0; i < n; i++) v = alu_f(op, a, v);
        return v;
    endfunction

    // Accumulator register environment
    logic       tb_set = 1'b0;
    logic [7:0] tb_set_val = 8'h00;
    logic [7:0] acc;
    always @(posedge CLK or posedge RESET) begin
        if (RESET)              acc <= 8'h00;
        else if (tb_set)        acc <= tb_set_val;
        else if (bus.acc_clear) acc <= 8'h00;
        else if (bus.acc_load)  acc <= alu_f(bus.alu_sel, bus.alu_a, acc);
    end
    assign bus.acc_value = acc;

    // Transaction-level model: m_t counts cycles since acceptance (0 = idle).
    bit         chk_en = 1'b0;
    int         m_t = 0;
    int         m_n = 0;
    int         m_j = 0;
    logic [2:0] m_op = 3'b000;
    logic [3:0] m_data = 4'h0;
    logic [7:0] m_acc = 8'h00;
    logic [7:0] m_res = 8'h00;

    always @(negedge CLK) begin
        int  last_ex;
        bit  ex, ld, cl, dn;
        if (chk_en) begin
            if (m_t > 0 && m_n > 0 && m_j == 0 && m_t <= m_n && bus.abort) m_j = m_t;
            ex = 0; ld = 0; cl = 0; dn = 0; last_ex = 0;
            if (m_t != 0 && m_n == 0) begin
                cl = (m_t == 1);
                dn = (m_t == 2);
            end else if (m_t != 0) begin
                last_ex = (m_j != 0) ? m_j : m_n;
                ex = (m_t <= last_ex);
                ld = ex && (m_t != m_j);
                dn = (m_t == last_ex + 1);
            end
            chk("cmd_ready", bus.cmd_ready, m_t == 0);
            chk("busy", bus.busy, m_t != 0);
            chk("acc_load", bus.acc_load, ld);
            chk("acc_clear", bus.acc_clear, cl);
            chk("done", bus.done, dn);
            chk("result", bus.result, m_res);
            if (dn) chk("aborted", bus.aborted, m_j != 0);
            if (ex) begin
                chk("alu_sel_exec", bus.alu_sel, m_op);
                chk("alu_a_exec", bus.alu_a, m_data);
            end
            if (m_t == 0) begin
                chk("alu_sel_idle", bus.alu_sel, 3'b001);
                chk("alu_a_idle", bus.alu_a, 4'h0);
                chk("acc_idle", acc, m_acc);
            end
            if (m_t == 0) begin
                if (bus.cmd_valid) begin
                    m_t = 1; m_n = int'(bus.cmd_count); m_j = 0;
                    m_op = bus.cmd_op; m_data = bus.cmd_data;
                end
            end else if (dn) begin
                m_acc = (m_n == 0) ? 8'h00
                      : model_apply(m_op, m_data, m_acc, (m_j != 0) ? m_j - 1 : m_n);
                m_res = m_acc;
                m_t = 0;
            end else begin
                m_t++;
            end
        end
    end

    task automatic tick;
        @(posedge CLK); #1;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [3:0] d, input logic [3:0] n,
                           input int ab_at, input bit hold,
                           output int nload, output int nclear, output int done_at, output logic ab);
        nload = 0; nclear = 0; done_at = 0; ab = 1'b0;
        chk("ready_before_cmd", bus.cmd_ready, 1'b1);
        bus.cmd_op = op; bus.cmd_data = d; bus.cmd_count = n; bus.cmd_valid = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (!hold) bus.cmd_valid = 1'b0;
            bus.abort = (i == ab_at);
            #1;
            if (bus.acc_load)  nload++;
            if (bus.acc_clear) nclear++;
            if (bus.done) begin
                done_at = i; ab = bus.aborted;
                break;
            end
        end
        bus.abort = 1'b0;
        if (done_at == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int   nl, nc, da, dl;
        logic ab;
        bit   pending, acc_edge;

        bus.cmd_valid = 1'b0; bus.cmd_op = 3'b000; bus.cmd_data = 4'h0;
        bus.cmd_count = 4'h0; bus.abort = 1'b0;

        chk("pin_model_add", model_apply(3'b110, 4'd3, 8'h00, 4), 32'h0C);
        chk("pin_model_add_wrap", model_apply(3'b110, 4'hF, 8'hF8, 1), 32'h07);

        // Reset state
        #1 RESET = 1'b1;
        #2;
        chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
        chk("rst_alu_sel", bus.alu_sel, 3'b001);
        chk("rst_acc_load", bus.acc_load, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_result", bus.result, 8'h00);
        repeat (2) tick();
        chk("rst_busy", bus.busy, 1'b0);
        @(negedge CLK) RESET = 1'b0;
        #1 chk("ready_low_until_edge", bus.cmd_ready, 1'b0);
        tick();
        chk("ready_after_release", bus.cmd_ready, 1'b1);

        // 4-step add
        run_cmd(3'b110, 4'd3, 4'd4, 0, 1'b0, nl, nc, da, ab);
        chk("add4_loads", nl, 4);
        chk("add4_done_at", da, 5);
        chk("add4_aborted", ab, 1'b0);
        tick();
        chk("add4_result", bus.result, 8'h0C);
        chk("add4_ready_again", bus.cmd_ready, 1'b1);

        // Zero-count clear
        tb_set_val = 8'h5A; tb_set = 1'b1;
        tick();
        tb_set = 1'b0;
        chk("preload_acc", acc, 8'h5A);
        run_cmd(3'b110, 4'd7, 4'd0, 0, 1'b0, nl, nc, da, ab);
        chk("clr_clears", nc, 1);
        chk("clr_loads", nl, 0);
        chk("clr_done_at", da, 2);
        tick();
        chk("clr_result", bus.result, 8'h00);

        // Abort on the 3rd EXEC cycle
        run_cmd(3'b110, 4'd1, 4'd5, 3, 1'b0, nl, nc, da, ab);
        chk("abort_loads", nl, 2);
        chk("abort_done_at", da, 4);
        chk("abort_flag", ab, 1'b1);
        tick();
        chk("abort_result", bus.result, 8'h02);

        // cmd_valid held: second accept only after done
        run_cmd(3'b110, 4'd1, 4'd2, 0, 1'b1, nl, nc, da, ab);
        chk("hold_loads", nl, 2);
        chk("hold_done_at", da, 3);
        tick();
        chk("hold_ready_after_done", bus.cmd_ready, 1'b1);
        chk("hold_result1", bus.result, 8'h04);
        tick();
        chk("hold_second_busy", bus.busy, 1'b1);
        chk("hold_second_load", bus.acc_load, 1'b1);
        bus.cmd_valid = 1'b0;
        dl = 0;
        for (int i = 0; i < 20 && dl == 0; i++) begin
            tick();
            if (bus.done) dl = 1;
        end
        chk("hold_second_done", dl, 1);
        tick();
        chk("hold_result2", bus.result, 8'h06);

        // Reset in the middle of EXEC
        bus.cmd_op = 3'b110; bus.cmd_data = 4'd1; bus.cmd_count = 4'd6; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        chk("mid_load_before_rst", bus.acc_load, 1'b1);
        #2 RESET = 1'b1;
        #1;
        chk("mid_rst_acc_load", bus.acc_load, 1'b0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_ready", bus.cmd_ready, 1'b0);
        dl = 0;
        repeat (3) begin
            tick();
            if (bus.done) dl = 1;
        end
        @(negedge CLK) RESET = 1'b0;
        repeat (3) begin
            tick();
            if (bus.done) dl = 1;
        end
        chk("mid_rst_no_done", dl, 0);
        chk("mid_rst_idle_ready", bus.cmd_ready, 1'b1);
        chk("mid_rst_result", bus.result, 8'h00);

        // Randomized run against the model
        chk_en = 1'b1;
        pending = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            acc_edge = bus.cmd_valid && bus.cmd_ready;
            tick();
            if (acc_edge) pending = 1'b0;
            if (!pending && $urandom_range(0, 2) == 0) begin
                bus.cmd_op    = 3'($urandom_range(0, 7));
                bus.cmd_data  = 4'($urandom_range(0, 15));
                bus.cmd_count = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
                pending = 1'b1;
            end
            bus.cmd_valid = pending;
            bus.abort = ($urandom_range(0, 11) == 0);
        end
        @(negedge CLK);
        chk_en = 1'b0;
        bus.abort = 1'b0;
        bus.cmd_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
